key_debouncer: RTL and testbench

Per-key synchronizer and debouncer for the board push-buttons. Raw active-low key lines enter; clean active-high level, single-cycle press pulse and single-cycle release pulse leave. Sits directly upstream of the value-capture/counter stage, which consumes `key_press_o` as its capture strobe with no further edge detection.

---
 rtl/key_debouncer.sv | 135 +++++++++++++
 tb/tb_key_debouncer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Per-key 2-FF synchronizer and debouncer: active-low raw keys in, registered level/press/release out.
// Optional auto-repeat of the press pulse while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debouncer #(
    parameter int KEYS          = 2,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk100_i,
    input  logic            rst_i,
    input  logic [KEYS-1:0] key_i,
    output logic [KEYS-1:0] key_level_o,
    output logic [KEYS-1:0] key_press_o,
    output logic [KEYS-1:0] key_release_o
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    // The counter must reach STABLE_CYCLES-1 without wrapping, so the range is checked at elaboration.
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debouncer: illegal parameter value");
    end

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        logic             sync1;
        logic             sync2;
        logic             pressed_s;
        state_t           state;
        logic [CNT_W-1:0] cnt;
`ifdef KEY_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_first;
`endif

        // Synchronizers reset to 1 so that a key reads as released out of reset.
        always_ff @(posedge clk100_i or posedge rst_i) begin
            if (rst_i) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= key_i[k];
                sync2 <= sync1;
            end
        end

        assign pressed_s = ~sync2;

        always_ff @(posedge clk100_i or posedge rst_i) begin
            if (rst_i) begin
                state            <= IDLE;
                cnt              <= '0;
                key_level_o[k]   <= 1'b0;
                key_press_o[k]   <= 1'b0;
                key_release_o[k] <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                rpt_cnt          <= '0;
                rpt_first        <= 1'b1;
`endif
            end else begin
                key_press_o[k]   <= 1'b0;
                key_release_o[k] <= 1'b0;
                case (state)
                    IDLE: begin
                        if (pressed_s) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed_s) begin
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            state          <= HELD;
                            key_level_o[k] <= 1'b1;
                            key_press_o[k] <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        // The repeat counter only advances here; a release glitch merely pauses it.
                        if (!pressed_s) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
`ifdef KEY_AUTOREPEAT_EN
                        else if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
                            key_press_o[k] <= 1'b1;
                            rpt_cnt        <= '0;
                            rpt_first      <= 1'b0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (pressed_s) begin
                            state <= HELD;
                        end else if (cnt == CNT_LAST) begin
                            state            <= IDLE;
                            key_level_o[k]   <= 1'b0;
                            key_release_o[k] <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                            rpt_cnt          <= '0;
                            rpt_first        <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer with STABLE_CYCLES=4; expected pulses are queued by the
// stimulus process and matched by a negedge monitor. Also covers KEY_AUTOREPEAT_EN builds.
module tb_key_debouncer;

    localparam int KEYS   = 2;
    localparam int STABLE = 4;

    logic            clk100_i = 1'b0;
    logic            rst_i    = 1'b1;
    logic [KEYS-1:0] key_i    = '0;
    logic [KEYS-1:0] key_level_o;
    logic [KEYS-1:0] key_press_o;
    logic [KEYS-1:0] key_release_o;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lvl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    key_debouncer #(
        .KEYS         (KEYS),
        .CNT_W        (20),
        .STABLE_CYCLES(STABLE),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk100_i     (clk100_i),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .key_level_o  (key_level_o),
        .key_press_o  (key_press_o),
        .key_release_o(key_release_o)
    );

    always #5 clk100_i = ~clk100_i;

    always @(posedge clk100_i) cyc <= cyc + 1;

    // Every pulse the DUT shows must be the oldest outstanding expectation, on the expected cycle.
    always @(negedge clk100_i) begin
        if (!rst_i && (key_press_o != 2'b00 || key_release_o != 2'b00)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: cycle %0d press=%b release=%b level=%b, required no pulse",
                         cyc, key_press_o, key_release_o, key_level_o);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc != cyc || key_press_o !== mon_e.press ||
                    key_release_o !== mon_e.rel || key_level_o !== mon_e.lvl) begin
                    errors++;
                    $display("[TB] FAIL pulse: got cycle %0d press=%b release=%b level=%b, required cycle %0d press=%b release=%b level=%b",
                             cyc, key_press_o, key_release_o, key_level_o,
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lvl);
                end
            end
        end
    end

    task automatic pushExpect(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lvl   = l;
        sb.push_back(e);
    endtask

    // Called at a negedge; the next rising edge is the first one to sample the new level.
    task automatic applyStimulus(input logic [1:0] keys, output int c);
        key_i = keys;
        c     = cyc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk100_i);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    initial begin
        int c;

        // Reset with both keys already pressed
        key_i = 2'b00;
        waitCycles(3);
        checkOutput("reset_level", key_level_o, 2'b00);
        checkOutput("reset_press", key_press_o, 2'b00);
        checkOutput("reset_release", key_release_o, 2'b00);
        rst_i = 1'b0;
        c = cyc;
        pushExpect(c + 7, 2'b11, 2'b00, 2'b11);
        waitCycles(9);
        checkOutput("reset_held_level", key_level_o, 2'b11);
        applyStimulus(2'b11, c);
        pushExpect(c + 7, 2'b00, 2'b11, 2'b00);
        waitCycles(10);
        checkOutput("reset_released_level", key_level_o, 2'b00);

        // Clean press and release of key0
        applyStimulus(2'b10, c);
        pushExpect(c + 7, 2'b01, 2'b00, 2'b01);
        waitCycles(9);
        checkOutput("press_level", key_level_o, 2'b01);
        applyStimulus(2'b11, c);
        pushExpect(c + 7, 2'b00, 2'b01, 2'b00);
        waitCycles(10);
        checkOutput("release_level", key_level_o, 2'b00);

        // Bounce: only the final stable low is accepted
        applyStimulus(2'b10, c);
        waitCycles(2);
        applyStimulus(2'b11, c);
        waitCycles(2);
        applyStimulus(2'b10, c);
        waitCycles(2);
        applyStimulus(2'b11, c);
        waitCycles(2);
        applyStimulus(2'b10, c);
        pushExpect(c + 7, 2'b01, 2'b00, 2'b01);
        waitCycles(9);

        // Two-cycle release glitch while held, then a real release
        applyStimulus(2'b11, c);
        waitCycles(2);
        applyStimulus(2'b10, c);
        waitCycles(3);
        checkOutput("glitch_level", key_level_o, 2'b01);
        applyStimulus(2'b11, c);
        pushExpect(c + 7, 2'b00, 2'b01, 2'b00);
        waitCycles(10);

        // Reset while key0 is held gives a fresh press afterwards
        applyStimulus(2'b10, c);
        pushExpect(c + 7, 2'b01, 2'b00, 2'b01);
        waitCycles(9);
        rst_i = 1'b1;
        waitCycles(2);
        checkOutput("midreset_level", key_level_o, 2'b00);
        checkOutput("midreset_press", key_press_o, 2'b00);
        rst_i = 1'b0;
        c = cyc;
        pushExpect(c + 7, 2'b01, 2'b00, 2'b01);
        waitCycles(9);
        applyStimulus(2'b11, c);
        pushExpect(c + 7, 2'b00, 2'b01, 2'b00);
        waitCycles(10);

        // Key0 press and key1 release sampled on the same edge
        applyStimulus(2'b01, c);
        pushExpect(c + 7, 2'b10, 2'b00, 2'b10);
        waitCycles(9);
        applyStimulus(2'b10, c);
        pushExpect(c + 7, 2'b01, 2'b10, 2'b01);
        waitCycles(9);
        applyStimulus(2'b11, c);
        pushExpect(c + 7, 2'b00, 2'b01, 2'b00);
        waitCycles(10);

        // Long hold of key0: repeat pulses only when auto-repeat is built in
        applyStimulus(2'b10, c);
        pushExpect(c + 7, 2'b01, 2'b00, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
        for (int i = 10; i <= 30; i += 5) pushExpect(c + 7 + i, 2'b01, 2'b00, 2'b01);
`endif
        waitCycles(38);
        checkOutput("repeat_level", key_level_o, 2'b01);
        applyStimulus(2'b11, c);
        pushExpect(c + 7, 2'b00, 2'b01, 2'b00);
        waitCycles(12);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_pulses: %0d expected pulses never seen, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
